// File: rtl/serial_word_collector.sv
// serial_word_collector
//   Collects a serial bit stream (MSB first) into WIDTH-bit parallel words and
//   hands each complete word downstream over a valid/ready handshake. The
//   partial word in progress can be aborted.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   bit_valid  in   bit_in is valid this cycle
//   bit_in     in   serial data bit, MSB of the word first
//   bit_ready  out  collector can take a bit this cycle
//   abort      in   discard the partial word being collected
//   word_valid out  word_out holds a complete word
//   word_out   out  assembled word; first bit received in [WIDTH-1]
//   word_ready in   downstream takes word_out this cycle
//   bit_cnt    out  bits collected so far in the current word
//
// state   | meaning
// --------+------------------------------------------------------------
// COLLECT | shifting bits in; bit_ready=1, word_valid=0
// HOLD    | complete word presented; waiting for word_ready
module serial_word_collector #(
   parameter int WIDTH = 15,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             bit_valid,
   input  logic             bit_in,
   output logic             bit_ready,
   input  logic             abort,
   output logic             word_valid,
   output logic [WIDTH-1:0] word_out,
   input  logic             word_ready,
   output logic [CNT_W-1:0] bit_cnt
);

   typedef enum logic [0:0] {
      COLLECT = 1'b0,
      HOLD    = 1'b1
   } state_t;

   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] sreg;
   logic [WIDTH-1:0] word_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic             accept;
   logic             accept_last;
   logic             handshake;

   always_comb begin
      state_nxt   = state;
      bit_ready   = 1'b0;
      word_valid  = 1'b0;
      accept      = 1'b0;
      accept_last = 1'b0;
      handshake   = 1'b0;
      case (state)
         COLLECT: begin
            bit_ready   = 1'b1;
            // abort wins over a coincident bit, even the final one
            accept      = bit_valid && !abort;
            accept_last = accept && (cnt_reg == LAST_BIT);
            if (accept_last) begin
               state_nxt = HOLD;
            end
         end
         HOLD: begin
            word_valid = 1'b1;
            handshake  = word_ready;
            if (handshake) begin
               state_nxt = COLLECT;
            end
         end
         default: begin
            state_nxt = COLLECT;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= COLLECT;
         sreg     <= '0;
         word_reg <= '0;
         cnt_reg  <= '0;
      end else begin
         state <= state_nxt;
         if (state == COLLECT) begin
            if (abort) begin
               sreg    <= '0;
               cnt_reg <= '0;
            end else if (accept) begin
               sreg <= {sreg[WIDTH-2:0], bit_in};
               if (accept_last) begin
                  cnt_reg <= '0;
                  // separate output register so word_out never shows a partial word
                  word_reg <= {sreg[WIDTH-2:0], bit_in};
               end else begin
                  cnt_reg <= cnt_reg + CNT_W'(1);
               end
            end
         end
      end
   end

   assign word_out = word_reg;
   assign bit_cnt  = cnt_reg;

endmodule

// File: tb/tb_serial_word_collector.sv
module tb_serial_word_collector;

   localparam int WIDTH = 15;
   localparam int CNT_W = 4;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             bit_valid = 1'b0;
   logic             bit_in = 1'b0;
   logic             bit_ready;
   logic             abort = 1'b0;
   logic             word_valid;
   logic [WIDTH-1:0] word_out;
   logic             word_ready = 1'b0;
   logic [CNT_W-1:0] bit_cnt;

   int checks   = 0;
   int failures = 0;

   // reference model: partial word as a queue of bits, plus the held/last word
   int m_bits[$];
   int m_hold = 0;
   int m_last = 0;
   int dut_words = 0;

   always #5 clk = ~clk;

   serial_word_collector #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .bit_valid  (bit_valid),
      .bit_in     (bit_in),
      .bit_ready  (bit_ready),
      .abort      (abort),
      .word_valid (word_valid),
      .word_out   (word_out),
      .word_ready (word_ready),
      .bit_cnt    (bit_cnt)
   );

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      if (obs != exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int bits_to_word();
      int w = 0;
      foreach (m_bits[i]) w = w * 2 + m_bits[i];
      return w;
   endfunction

   task automatic model_update(input int r, input int bv, input int bi, input int ab,
                               input int wr);
      if (r != 0) begin
         m_bits.delete();
         m_hold = 0;
         m_last = 0;
      end else if (m_hold != 0) begin
         if (wr != 0) m_hold = 0;
      end else if (ab != 0) begin
         m_bits.delete();
      end else if (bv != 0) begin
         m_bits.push_back(bi);
         if (m_bits.size() == WIDTH) begin
            m_last = bits_to_word();
            m_bits.delete();
            m_hold = 1;
         end
      end
   endtask

   // drive one cycle of inputs, advance the model, then check all outputs
   task automatic step(input int bv, input int bi, input int ab, input int wr, input int r);
      bit_valid  = bv[0];
      bit_in     = bi[0];
      abort      = ab[0];
      word_ready = wr[0];
      rst        = r[0];
      model_update(r, bv, bi, ab, wr);
      @(posedge clk);
      #1;
      chk("bit_ready", int'(bit_ready), (m_hold != 0) ? 0 : 1);
      chk("word_valid", int'(word_valid), m_hold);
      chk("bit_cnt", int'(bit_cnt), m_bits.size());
      chk("word_out", int'(word_out), m_last);
      if (word_valid && word_ready) dut_words++;
   endtask

   task automatic send_word(input logic [WIDTH-1:0] w, input int wr);
      logic [WIDTH-1:0] v;
      v = w;
      for (int i = WIDTH - 1; i >= 0; i--) step(1, int'(v[i]), 0, wr, 0);
   endtask

   initial begin
      logic [WIDTH-1:0] pat;
      int start_words;

      // reset
      step(0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 1);
      chk("reset_word_out", int'(word_out), 0);

      // basic: 101011011100110 with word_ready high
      pat = 15'b101011011100110;
      send_word(pat, 1);
      chk("basic_word_out", int'(word_out), 'h56E6);
      chk("basic_bit_ready", int'(bit_ready), 0);
      step(0, 0, 0, 1, 0);
      chk("basic_vld_drop", int'(word_valid), 0);

      // backpressure: hold with extra bit pulses ignored
      pat = 15'b000001000000000;
      send_word(pat, 0);
      for (int i = 0; i < 5; i++) begin
         step(1, 1, 0, 0, 0);
         chk("bp_word_out", int'(word_out), 'h0200);
      end
      step(0, 0, 0, 1, 0);

      // abort after 7 bits, abort coincident with a valid bit
      for (int i = 0; i < 7; i++) step(1, i % 2, 0, 0, 0);
      step(1, 1, 1, 0, 0);
      chk("abort_bit_cnt", int'(bit_cnt), 0);
      send_word('1, 0);
      chk("abort_word_out", int'(word_out), 'h7FFF);
      step(0, 0, 1, 1, 0);

      // gapped input
      for (int i = 0; i < 2 * WIDTH; i++) step((i % 2 == 0) ? 1 : 0, 1, 0, 1, 0);
      step(0, 0, 0, 1, 0);
      chk("gap_word_out", int'(word_out), 'h7FFF);

      // mid-word reset
      for (int i = 0; i < 10; i++) step(1, 1, 0, 1, 0);
      step(0, 0, 0, 1, 1);
      start_words = dut_words;
      pat = 15'b100000000000000;
      send_word(pat, 1);
      step(0, 0, 0, 1, 0);
      chk("reset_word_count", dut_words - start_words, 1);
      chk("reset_word_out", int'(word_out), 'h4000);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         step(($urandom_range(0, 3) != 0) ? 1 : 0,
              int'($urandom_range(0, 1)),
              ($urandom_range(0, 19) == 0) ? 1 : 0,
              int'($urandom_range(0, 1)),
              ($urandom_range(0, 299) == 0) ? 1 : 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
